// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and a saturating counter of load-use bubbles.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   valid_d, *_d             decoded instruction from the ID stage
//   flush                    taken branch/jump in EX: squash decode instr
//   hold_ex                  EX busy: freeze the EX register
//   valid_e, *_e             registered EX-stage copy of the decode bundle
//   stall_fd                 freeze IF and IF/ID this cycle
//   bubble_count             saturating count of load-use bubbles
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic             RegWrite_d,
  input  logic             ALUSrc_d,
  input  logic             MemRead_d,
  input  logic             MemWrite_d,
  input  logic             MemToReg_d,
  input  logic             Branch_d,
  input  logic             Jump_d,
  input  logic [3:0]       ALUOp_d,
  input  logic [31:0]      pc_d,
  input  logic [31:0]      rs1_data_d,
  input  logic [31:0]      rs2_data_d,
  input  logic [31:0]      imm_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic [2:0]       funct3_d,
  input  logic             flush,
  input  logic             hold_ex,
  output logic             valid_e,
  output logic             RegWrite_e,
  output logic             ALUSrc_e,
  output logic             MemRead_e,
  output logic             MemWrite_e,
  output logic             MemToReg_e,
  output logic             Branch_e,
  output logic             Jump_e,
  output logic [3:0]       ALUOp_e,
  output logic [31:0]      pc_e,
  output logic [31:0]      rs1_data_e,
  output logic [31:0]      rs2_data_e,
  output logic [31:0]      imm_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic [2:0]       funct3_e,
  output logic             stall_fd,
  output logic [CNT_W-1:0] bubble_count
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        alusrc;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        branch;
    logic        jump;
    logic [3:0]  aluop;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } id_ex_t;

  id_ex_t           dec;
  id_ex_t           ex_q;
  id_ex_t           ex_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             use_rs1;
  logic             use_rs2;
  logic             hz;

  always_comb begin
    dec          = '0;
    dec.valid    = valid_d;
    dec.regwrite = RegWrite_d;
    dec.alusrc   = ALUSrc_d;
    dec.memread  = MemRead_d;
    dec.memwrite = MemWrite_d;
    dec.memtoreg = MemToReg_d;
    dec.branch   = Branch_d;
    dec.jump     = Jump_d;
    dec.aluop    = ALUOp_d;
    dec.pc       = pc_d;
    dec.rs1_data = rs1_data_d;
    dec.rs2_data = rs2_data_d;
    dec.imm      = imm_d;
    dec.rs1      = rs1_d;
    dec.rs2      = rs2_d;
    dec.rd       = rd_d;
    dec.funct3   = funct3_d;
  end

  // Stores read rs2 even though ALUSrc selects the immediate.
  assign use_rs1 = valid_d && !Jump_d;
  assign use_rs2 = valid_d &&
                   ((!ALUSrc_d && !Jump_d) || MemWrite_d);

  assign hz = ex_q.valid && ex_q.memread &&
              (ex_q.rd != 5'd0) &&
              ((use_rs1 && (rs1_d == ex_q.rd)) ||
               (use_rs2 && (rs2_d == ex_q.rd)));

  assign stall_fd = (hz || hold_ex) && !flush && !rst;

  // Conditions overlap, so evaluation order sets the priority.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    priority case (1'b1)
      flush:   ex_d = '0;
      hold_ex: ex_d = ex_q;
      hz: begin
        ex_d = '0;
        if (cnt_q != '1)
          cnt_d = cnt_q + CNT_W'(1);
      end
      default: ex_d = valid_d ? dec : '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_e      = ex_q.valid;
  assign RegWrite_e   = ex_q.regwrite;
  assign ALUSrc_e     = ex_q.alusrc;
  assign MemRead_e    = ex_q.memread;
  assign MemWrite_e   = ex_q.memwrite;
  assign MemToReg_e   = ex_q.memtoreg;
  assign Branch_e     = ex_q.branch;
  assign Jump_e       = ex_q.jump;
  assign ALUOp_e      = ex_q.aluop;
  assign pc_e         = ex_q.pc;
  assign rs1_data_e   = ex_q.rs1_data;
  assign rs2_data_e   = ex_q.rs2_data;
  assign imm_e        = ex_q.imm;
  assign rs1_e        = ex_q.rs1;
  assign rs2_e        = ex_q.rs2;
  assign rd_e         = ex_q.rd;
  assign funct3_e     = ex_q.funct3;
  assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expected
// stall/EX/count; a negedge monitor pops and compares.
module tb_id_ex_stage;

  typedef struct packed {
    logic        v, rw, as, mr, mw, m2r, br, j;
    logic [3:0]  op;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  r1, r2, rd;
    logic [2:0]  f3;
  } vec_t;

  typedef struct {
    logic        stall;
    vec_t        ex;
    logic [15:0] cnt;
  } exp_t;

  localparam int A_LD = 0;
  localparam int A_FL = 1;
  localparam int A_HZ = 2;
  localparam int A_HD = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic hold_ex = 1'b0;
  vec_t d = '0;

  logic valid_e, RegWrite_e, ALUSrc_e, MemRead_e, MemWrite_e;
  logic MemToReg_e, Branch_e, Jump_e, stall_fd;
  logic [3:0]  ALUOp_e;
  logic [31:0] pc_e, rs1_data_e, rs2_data_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [2:0]  funct3_e;
  logic [15:0] bubble_count;
  vec_t act;

  vec_t       s_act;
  logic       s_stall;
  logic [2:0] s_cnt;

  exp_t        q[$];
  vec_t        exp_ex = '0;
  logic [15:0] exp_cnt = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .valid_d(d.v),
    .RegWrite_d(d.rw), .ALUSrc_d(d.as), .MemRead_d(d.mr),
    .MemWrite_d(d.mw), .MemToReg_d(d.m2r), .Branch_d(d.br),
    .Jump_d(d.j), .ALUOp_d(d.op), .pc_d(d.pc),
    .rs1_data_d(d.a), .rs2_data_d(d.b), .imm_d(d.imm),
    .rs1_d(d.r1), .rs2_d(d.r2), .rd_d(d.rd), .funct3_d(d.f3),
    .flush(flush), .hold_ex(hold_ex),
    .valid_e(valid_e), .RegWrite_e(RegWrite_e),
    .ALUSrc_e(ALUSrc_e), .MemRead_e(MemRead_e),
    .MemWrite_e(MemWrite_e), .MemToReg_e(MemToReg_e),
    .Branch_e(Branch_e), .Jump_e(Jump_e), .ALUOp_e(ALUOp_e),
    .pc_e(pc_e), .rs1_data_e(rs1_data_e),
    .rs2_data_e(rs2_data_e), .imm_e(imm_e), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .rd_e(rd_e), .funct3_e(funct3_e),
    .stall_fd(stall_fd), .bubble_count(bubble_count)
  );

  // Narrow counter copy: saturation reachable in few cycles.
  id_ex_stage #(.CNT_W(3)) sat (
    .clk(clk), .rst(rst), .valid_d(d.v),
    .RegWrite_d(d.rw), .ALUSrc_d(d.as), .MemRead_d(d.mr),
    .MemWrite_d(d.mw), .MemToReg_d(d.m2r), .Branch_d(d.br),
    .Jump_d(d.j), .ALUOp_d(d.op), .pc_d(d.pc),
    .rs1_data_d(d.a), .rs2_data_d(d.b), .imm_d(d.imm),
    .rs1_d(d.r1), .rs2_d(d.r2), .rd_d(d.rd), .funct3_d(d.f3),
    .flush(flush), .hold_ex(hold_ex),
    .valid_e(s_act.v), .RegWrite_e(s_act.rw),
    .ALUSrc_e(s_act.as), .MemRead_e(s_act.mr),
    .MemWrite_e(s_act.mw), .MemToReg_e(s_act.m2r),
    .Branch_e(s_act.br), .Jump_e(s_act.j), .ALUOp_e(s_act.op),
    .pc_e(s_act.pc), .rs1_data_e(s_act.a),
    .rs2_data_e(s_act.b), .imm_e(s_act.imm), .rs1_e(s_act.r1),
    .rs2_e(s_act.r2), .rd_e(s_act.rd), .funct3_e(s_act.f3),
    .stall_fd(s_stall), .bubble_count(s_cnt)
  );

  assign act = {valid_e, RegWrite_e, ALUSrc_e, MemRead_e,
                MemWrite_e, MemToReg_e, Branch_e, Jump_e,
                ALUOp_e, pc_e, rs1_data_e, rs2_data_e, imm_e,
                rs1_e, rs2_e, rd_e, funct3_e};

  task automatic chk(input string nm,
                     input logic [199:0] got,
                     input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: each cycle with a pending entry, compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("stall_fd", 200'(stall_fd), 200'(e.stall));
        chk("ex_regs", 200'(act), 200'(e.ex));
        chk("bubble_count", 200'(bubble_count), 200'(e.cnt));
      end
    end
  end

  // Issue the current d for one cycle with hand-derived outcome.
  task automatic go(input logic es, input int a);
    exp_t e;
    e.stall = es;
    e.ex    = exp_ex;
    e.cnt   = exp_cnt;
    q.push_back(e);
    case (a)
      A_LD: exp_ex = d.v ? d : '0;
      A_FL: exp_ex = '0;
      A_HZ: begin
        exp_ex = '0;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [31:0] pc);
    d = '0;
    d.v = 1; d.rw = 1; d.as = 1; d.mr = 1; d.m2r = 1;
    d.f3 = 3'b010; d.r1 = 5'd2; d.rd = rd; d.imm = 32'd8;
    d.pc = pc;
  endtask

  task automatic rtype(input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] pc);
    d = '0;
    d.v = 1; d.rw = 1; d.op = 4'b0000;
    d.r1 = r1; d.r2 = r2; d.rd = rd; d.pc = pc;
    d.a = 32'h11 + 32'(r1); d.b = 32'h22 + 32'(r2);
  endtask

  task automatic lw_use(input logic [4:0] rd, input logic [31:0] pc);
    ld(rd, pc);
    go(0, A_LD);
    rtype(rd, 5'd1, 5'd20, pc + 4);
    go(1, A_HZ);
    go(0, A_LD);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: immediate bubble, stall suppressed even with hold_ex.
    hold_ex = 1;
    ld(5'd4, 32'h40);
    #1 rst = 1;
    #1;
    chk("rst_ex", 200'(act), 200'(0));
    chk("rst_cnt", 200'(bubble_count), 200'(0));
    chk("rst_stall", 200'(stall_fd), 200'(0));
    @(negedge clk);
    chk("rst_hold_ex", 200'(act), 200'(0));
    hold_ex = 0;
    d = '0;
    rst = 0;
    @(posedge clk);
    #1;

    // Pass-through ADD.
    rtype(5'd1, 5'd2, 5'd5, 32'h100);
    d.a = 32'd7; d.b = 32'd9;
    go(0, A_LD);
    // LW rd=3, then R-type using rs2=3: one bubble.
    ld(5'd3, 32'h104);
    go(0, A_LD);
    rtype(5'd1, 5'd3, 5'd6, 32'h108);
    go(1, A_HZ);
    go(0, A_LD);
    // ADDI with rs2 field matching a load rd: no hazard.
    ld(5'd3, 32'h10c);
    go(0, A_LD);
    d = '0;
    d.v = 1; d.rw = 1; d.as = 1; d.r1 = 5'd4; d.r2 = 5'd3;
    d.rd = 5'd7; d.imm = 32'hFFFF_FFFC; d.pc = 32'h110;
    go(0, A_LD);
    // Load to x0, consumer reads x0: no hazard.
    ld(5'd0, 32'h114);
    go(0, A_LD);
    rtype(5'd0, 5'd0, 5'd8, 32'h118);
    go(0, A_LD);
    // JAL does not read registers.
    ld(5'd7, 32'h11c);
    go(0, A_LD);
    d = '0;
    d.v = 1; d.rw = 1; d.j = 1; d.r1 = 5'd7; d.r2 = 5'd7;
    d.rd = 5'd1; d.imm = 32'h40; d.pc = 32'h120;
    go(0, A_LD);
    // Store data on rs2 despite ALUSrc=1.
    ld(5'd8, 32'h160);
    go(0, A_LD);
    d = '0;
    d.v = 1; d.as = 1; d.mw = 1; d.r1 = 5'd2; d.r2 = 5'd8;
    d.imm = 32'h10; d.f3 = 3'b010; d.pc = 32'h164;
    go(1, A_HZ);
    go(0, A_LD);
    // Flush beats hold and hazard; count unchanged.
    ld(5'd9, 32'h168);
    go(0, A_LD);
    rtype(5'd9, 5'd9, 5'd10, 32'h16c);
    flush = 1; hold_ex = 1;
    go(0, A_FL);
    flush = 0; hold_ex = 0;
    // Invalid decode with control bits set loads as a bubble.
    d = '1;
    d.v = 0;
    go(0, A_LD);
    // Hold three cycles with changing inputs.
    rtype(5'd11, 5'd12, 5'd13, 32'h200);
    d.f3 = 3'b111; d.op = 4'b1000; d.br = 1;
    go(0, A_LD);
    hold_ex = 1;
    for (int i = 0; i < 3; i++) begin
      rtype(5'(i), 5'(i + 1), 5'(i + 2), 32'h300 + 32'(i));
      go(1, A_HD);
    end
    hold_ex = 0;
    rtype(5'd14, 5'd15, 5'd16, 32'h400);
    go(0, A_LD);
    // Three more load-use pairs bring the count to 5.
    lw_use(5'd12, 32'h500);
    lw_use(5'd13, 32'h510);
    lw_use(5'd14, 32'h520);
    chk("pre_rst_valid", 200'(valid_e), 200'(1));
    chk("pre_rst_cnt", 200'(bubble_count), 200'(5));
    // Reset mid-hold: immediate clear, held instr dropped.
    hold_ex = 1;
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", 200'(valid_e), 200'(0));
    chk("mid_rst_rw", 200'(RegWrite_e), 200'(0));
    chk("mid_rst_cnt", 200'(bubble_count), 200'(0));
    chk("mid_rst_stall", 200'(stall_fd), 200'(0));
    @(negedge clk);
    rst = 0; hold_ex = 0; d = '0;
    @(posedge clk);
    #1;
    exp_ex = '0;
    exp_cnt = '0;
    // Nine hazards: 3-bit counter must stick at 7.
    for (int i = 0; i < 9; i++)
      lw_use(5'(17 + (i % 4)), 32'h600 + 32'(16 * i));
    d = '0;
    go(0, A_LD);
    chk("sat_cnt", 200'(s_cnt), 200'(3'h7));
    chk("sat_ex", 200'(s_act), 200'(act));
    chk("sat_stall", 200'(s_stall), 200'(stall_fd));
    for (int i = 0; i < 5 && q.size() != 0; i++)
      @(posedge clk);
    chk("queue_drain", 200'(q.size()), 200'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
